cache_memory_stream: RTL and testbench
======================================

CACHE_MEMORY_STREAM -- requirements
Module: cache_memory_stream

Interface
REQ-001 Parameter BW_DATA, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter N_BLOCKS, default 64, blocks per way; power of two, >=2.
REQ-003 Parameter N_WORDS_PER_BLOCK, default 4, words per block; power of two, >=2.
REQ-004 Parameter N_WAYS, default 2, associativity; power of two, >=1.
REQ-005 Derived widths: BW_ADDR=clog2(N_BLOCKS), BW_OFFSET=clog2(N_WORDS_PER_BLOCK), BW_WAY=max(1,clog2(N_WAYS)), BW_BE=BW_DATA/8.
REQ-006 Ports, clock and reset first:
clock_i  in  1  sole clock, rising edge
reset_i  in  1  asynchronous, active-high reset
rd_i  in  1  single-word read request
wr_i  in  1  single-word write request
be_i  in  BW_BE  byte enables for wr_i
way_i  in  BW_WAY  target way for every command
addr_i  in  BW_ADDR  block address for every command
offset_i  in  BW_OFFSET  word offset for rd_i/wr_i
data_i  in  BW_DATA  write data for wr_i
data_o  out  BW_DATA  read word
rd_valid_o  out  1  data_o valid pulse
fill_start_i  in  1  begin block fill
fill_valid_i  in  1  fill word present
fill_data_i  in  BW_DATA  fill word
fill_ready_o  out  1  fill word accepted when high with fill_valid_i
fill_done_o  out  1  one-cycle pulse, fill complete
evict_start_i  in  1  begin block readout
evict_valid_o  out  1  evict word present
evict_data_o  out  BW_DATA  evict word
evict_ready_i  in  1  downstream accepts evict word
busy_o  out  1  high whenever FSM not IDLE

Function
REQ-007 Storage: N_WAYS x N_WORDS_PER_BLOCK synchronous-read embedded memory_embedded instances of N_BLOCKS x BW_DATA, 1-cycle read latency, per-byte write enable.
REQ-008 FSM states IDLE, FILL, EVICT_RD, EVICT_OUT; commands accepted only in IDLE.
REQ-009 IDLE priority for same-cycle commands: fill_start_i > evict_start_i > wr_i > rd_i; lower-priority commands that cycle are dropped, no side effect.
REQ-010 Read: rd_i accepted at edge N -> data_o = mem[way_i][addr_i][offset_i], rd_valid_o=1 for exactly cycle N+1; data_o holds value until next read completes.
REQ-011 Write: wr_i accepted at edge N -> bytes k with be_i[k]=1 updated at edge N; be_i=0 writes nothing; read of same location issued at N+1 returns new data.
REQ-012 Fill: fill_start_i latches way_i, addr_i, clears word counter, -> FILL; fill_ready_o=1 throughout FILL.
REQ-013 In FILL, each cycle with fill_valid_i=1 writes fill_data_i (all bytes) to word counter of latched block and increments counter; fill_valid_i=0 stalls without effect.
REQ-014 Acceptance of word N_WORDS_PER_BLOCK-1 -> fill_done_o=1 next cycle, FSM returns IDLE same edge; counter wraps to 0.
REQ-015 Evict: evict_start_i latches way/addr, counter=0, -> EVICT_RD; EVICT_RD issues read of current word, -> EVICT_OUT next edge.
REQ-016 EVICT_OUT: evict_valid_o=1, evict_data_o=read word, held stable until evict_ready_i=1; on handshake counter increments and -> EVICT_RD, or -> IDLE after last word.
REQ-017 Evict words emerge in ascending offset order 0..N_WORDS_PER_BLOCK-1; fill expects the same order.
REQ-018 rd_i, wr_i, fill_start_i, evict_start_i asserted while busy_o=1 are ignored; fill_valid_i outside FILL ignored; memory contents unchanged.
REQ-019 Only latched way/addr used during FILL/EVICT; way_i/addr_i changes mid-operation have no effect.

Reset
REQ-020 reset_i=1 forces immediately: FSM IDLE, counter 0, rd_valid_o, fill_ready_o, fill_done_o, evict_valid_o, busy_o = 0, data_o and evict_data_o = 0.
REQ-021 Reset mid-fill or mid-evict aborts operation; words already written remain; memory array is never cleared by reset.

Verification
REQ-022 V1: wr_i way1 addr5 off2 data 0xDEADBEEF be 0xF, then rd_i -> data_o=0xDEADBEEF, rd_valid_o one cycle after rd_i.
REQ-023 V2: wr be 0x3 data 0x0000AAAA over 0x12345678 -> readback 0x1234AAAA.
REQ-024 V3: fill way0 addr3 words 0x10..0x13 with fill_valid_i gaps -> fill_done_o pulse once after 4th word; evict same block with evict_ready_i toggled -> 0x10,0x11,0x12,0x13 in order, each held while ready=0.
REQ-025 V4: fill_start_i and wr_i same IDLE cycle -> fill entered, write dropped; rd_i during FILL -> no rd_valid_o.
REQ-026 V5: reset_i asserted after 2 fill words -> outputs zero immediately, IDLE; words 0..1 read back, words 2..3 unchanged.
REQ-027 V6: N_WAYS=4, N_WORDS_PER_BLOCK=8 instance: write distinct pattern every way/offset of one addr -> all read back correctly, no cross-way aliasing.

Source files
------------

// File: rtl/cache_memory_stream.sv
// cache_memory_stream: set-associative block store with word access, streamed block fill and evict
module memory_embedded #(
  parameter int BW_DATA = 32,
  parameter int N_ENTRIES = 64,
  localparam int BW_ADDR = $clog2(N_ENTRIES),
  localparam int BW_BE = BW_DATA / 8
) (
  input  logic               clk,
  input  logic [BW_BE-1:0]   we,
  input  logic               re,
  input  logic [BW_ADDR-1:0] addr,
  input  logic [BW_DATA-1:0] wdata,
  output logic [BW_DATA-1:0] rdata
);
  logic [BW_DATA-1:0] mem [N_ENTRIES];
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int k = 0; k < BW_BE; k++)
      if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
  end
endmodule

module cache_memory_stream #(
  parameter int BW_DATA = 32,
  parameter int N_BLOCKS = 64,
  parameter int N_WORDS_PER_BLOCK = 4,
  parameter int N_WAYS = 2,
  localparam int BW_ADDR = $clog2(N_BLOCKS),
  localparam int BW_OFFSET = $clog2(N_WORDS_PER_BLOCK),
  localparam int BW_WAY = N_WAYS > 1 ? $clog2(N_WAYS) : 1,
  localparam int BW_BE = BW_DATA / 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 rd_i,
  input  logic                 wr_i,
  input  logic [BW_BE-1:0]     be_i,
  input  logic [BW_WAY-1:0]    way_i,
  input  logic [BW_ADDR-1:0]   addr_i,
  input  logic [BW_OFFSET-1:0] offset_i,
  input  logic [BW_DATA-1:0]   data_i,
  output logic [BW_DATA-1:0]   data_o,
  output logic                 rd_valid_o,
  input  logic                 fill_start_i,
  input  logic                 fill_valid_i,
  input  logic [BW_DATA-1:0]   fill_data_i,
  output logic                 fill_ready_o,
  output logic                 fill_done_o,
  input  logic                 evict_start_i,
  output logic                 evict_valid_o,
  output logic [BW_DATA-1:0]   evict_data_o,
  input  logic                 evict_ready_i,
  output logic                 busy_o
);
  localparam int N_MEM = N_WAYS * N_WORDS_PER_BLOCK;
  typedef enum logic [1:0] {IDLE, FILL, EVICT_RD, EVICT_OUT} state_t;
  state_t state, state_nx;
  logic [BW_WAY-1:0] lat_way, rd_way;
  logic [BW_ADDR-1:0] lat_addr, mem_addr;
  logic [BW_OFFSET-1:0] cnt, rd_off;
  logic [BW_DATA-1:0] rdata [N_MEM];
  logic [BW_BE-1:0] we [N_MEM];
  logic re [N_MEM];
  logic [BW_DATA-1:0] rd_word, ev_word, data_q, mem_wdata;
  logic idle, fill_go, evict_go, wr_go, rd_go, fill_acc, ev_hs, last, rd_valid_q, fill_done_q;
  assign idle = state == IDLE;
  assign fill_go = idle && fill_start_i;
  assign evict_go = idle && evict_start_i && !fill_start_i;
  assign wr_go = idle && wr_i && !fill_start_i && !evict_start_i;
  assign rd_go = idle && rd_i && !fill_start_i && !evict_start_i && !wr_i;
  assign fill_acc = state == FILL && fill_valid_i;
  assign ev_hs = state == EVICT_OUT && evict_ready_i;
  assign last = cnt == BW_OFFSET'(N_WORDS_PER_BLOCK - 1);
  assign mem_addr = idle ? addr_i : lat_addr;
  assign mem_wdata = fill_acc ? fill_data_i : data_i;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = fill_start_i ? FILL : evict_start_i ? EVICT_RD : IDLE;
      FILL:      state_nx = fill_valid_i && last ? IDLE : FILL;
      EVICT_RD:  state_nx = EVICT_OUT;
      EVICT_OUT: state_nx = !evict_ready_i ? EVICT_OUT : last ? IDLE : EVICT_RD;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
      lat_way <= '0;
      lat_addr <= '0;
      rd_way <= '0;
      rd_off <= '0;
      rd_valid_q <= 1'b0;
      fill_done_q <= 1'b0;
      data_q <= '0;
    end else begin
      rd_valid_q <= rd_go;
      fill_done_q <= fill_acc && last;
      if (rd_go) {rd_way, rd_off} <= {way_i, offset_i};
      if (rd_valid_q) data_q <= rd_word;
      if (fill_go || evict_go) begin
        lat_way <= way_i;
        lat_addr <= addr_i;
        cnt <= '0;
      end else if (fill_acc || ev_hs) cnt <= cnt + 1'b1;
    end
  end
  for (genvar w = 0; w < N_WAYS; w++) begin : g_way
    for (genvar o = 0; o < N_WORDS_PER_BLOCK; o++) begin : g_word
      localparam int I = w * N_WORDS_PER_BLOCK + o;
      logic cmd_hit, lat_hit;
      assign cmd_hit = way_i == BW_WAY'(w) && offset_i == BW_OFFSET'(o);
      assign lat_hit = lat_way == BW_WAY'(w) && cnt == BW_OFFSET'(o);
      assign we[I] = wr_go && cmd_hit ? be_i : fill_acc && lat_hit ? '1 : '0;
      assign re[I] = rd_go && cmd_hit || state == EVICT_RD && lat_hit;
      memory_embedded #(.BW_DATA(BW_DATA), .N_ENTRIES(N_BLOCKS)) u_mem (
        .clk(clock_i), .we(we[I]), .re(re[I]), .addr(mem_addr), .wdata(mem_wdata), .rdata(rdata[I])
      );
    end
  end
  always_comb begin
    rd_word = '0;
    ev_word = '0;
    for (int i = 0; i < N_MEM; i++) begin
      rd_word = i == int'(rd_way) * N_WORDS_PER_BLOCK + int'(rd_off) ? rdata[i] : rd_word;
      ev_word = i == int'(lat_way) * N_WORDS_PER_BLOCK + int'(cnt) ? rdata[i] : ev_word;
    end
  end
  // data_o follows the memory in the valid cycle, then holds the captured word
  assign data_o = rd_valid_q ? rd_word : data_q;
  assign rd_valid_o = rd_valid_q;
  assign fill_ready_o = state == FILL;
  assign fill_done_o = fill_done_q;
  assign evict_valid_o = state == EVICT_OUT;
  assign evict_data_o = state == EVICT_OUT ? ev_word : '0;
  assign busy_o = !idle;
endmodule

// File: tb/tb_cache_memory_stream.sv
// tb_cache_memory_stream: directed self-checking bench for cache_memory_stream
module tb_cache_memory_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic rd, wr, fill_start, fill_valid, evict_start, evict_ready;
  logic [3:0] be;
  logic [0:0] way;
  logic [5:0] addr;
  logic [1:0] off;
  logic [31:0] wdata, fill_data, rdata, ev_data;
  logic rd_valid, fill_ready, fill_done, ev_valid, busy;
  logic b_rd, b_wr, b_rd_valid, b_fill_ready, b_fill_done, b_ev_valid, b_busy;
  logic [1:0] b_way;
  logic [5:0] b_addr;
  logic [2:0] b_off;
  logic [31:0] b_wdata, b_rdata, b_ev_data;
  int total = 0, passed = 0;

  cache_memory_stream dut_a (
    .clock_i(clk), .reset_i(rst), .rd_i(rd), .wr_i(wr), .be_i(be), .way_i(way), .addr_i(addr),
    .offset_i(off), .data_i(wdata), .data_o(rdata), .rd_valid_o(rd_valid), .fill_start_i(fill_start),
    .fill_valid_i(fill_valid), .fill_data_i(fill_data), .fill_ready_o(fill_ready), .fill_done_o(fill_done),
    .evict_start_i(evict_start), .evict_valid_o(ev_valid), .evict_data_o(ev_data),
    .evict_ready_i(evict_ready), .busy_o(busy)
  );

  cache_memory_stream #(.N_WAYS(4), .N_WORDS_PER_BLOCK(8)) dut_b (
    .clock_i(clk), .reset_i(rst), .rd_i(b_rd), .wr_i(b_wr), .be_i(4'hF), .way_i(b_way), .addr_i(b_addr),
    .offset_i(b_off), .data_i(b_wdata), .data_o(b_rdata), .rd_valid_o(b_rd_valid), .fill_start_i(1'b0),
    .fill_valid_i(1'b0), .fill_data_i(32'h0), .fill_ready_o(b_fill_ready), .fill_done_o(b_fill_done),
    .evict_start_i(1'b0), .evict_valid_o(b_ev_valid), .evict_data_o(b_ev_data),
    .evict_ready_i(1'b0), .busy_o(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wr_a(input logic w, input logic [5:0] a, input logic [1:0] o, input logic [31:0] d, input logic [3:0] b);
    way = w; addr = a; off = o; wdata = d; be = b; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic w, input logic [5:0] a, input logic [1:0] o, input logic [31:0] exp);
    way = w; addr = a; off = o; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check({tag, "_vld"}, 32'(rd_valid), 32'd1);
    check(tag, rdata, exp);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rd_valid), 32'd0);
    check({tag, "_hold"}, rdata, exp);
  endtask

  task automatic wr_b(input logic [1:0] w, input logic [2:0] o, input logic [31:0] d);
    b_way = w; b_addr = 6'd10; b_off = o; b_wdata = d; b_wr = 1'b1;
    @(negedge clk);
    b_wr = 1'b0;
  endtask

  task automatic rd_b(input string tag, input logic [1:0] w, input logic [2:0] o, input logic [31:0] exp);
    b_way = w; b_addr = 6'd10; b_off = o; b_rd = 1'b1;
    @(negedge clk);
    b_rd = 1'b0;
    check({tag, "_vld"}, 32'(b_rd_valid), 32'd1);
    check(tag, b_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] pat;
    int k, n, done_cnt;
    rd = 0; wr = 0; fill_start = 0; fill_valid = 0; evict_start = 0; evict_ready = 0;
    be = 0; way = 0; addr = 0; off = 0; wdata = 0; fill_data = 0;
    b_rd = 0; b_wr = 0; b_way = 0; b_addr = 0; b_off = 0; b_wdata = 0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_data", rdata, 0);
    check("rst_rdv", 32'(rd_valid), 0);
    check("rst_frdy", 32'(fill_ready), 0);
    check("rst_fdone", 32'(fill_done), 0);
    check("rst_evv", 32'(ev_valid), 0);
    check("rst_evd", ev_data, 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    // single-word write/read, byte enables and way separation
    wr_a(1, 5, 2, 32'hDEADBEEF, 4'hF);
    rd_a("v1", 1, 5, 2, 32'hDEADBEEF);
    wr_a(0, 1, 0, 32'h12345678, 4'hF);
    wr_a(0, 1, 0, 32'h0000AAAA, 4'h3);
    rd_a("v2", 0, 1, 0, 32'h1234AAAA);
    wr_a(0, 1, 0, 32'h0, 4'h0);
    rd_a("be0", 0, 1, 0, 32'h1234AAAA);
    wr_a(0, 5, 2, 32'h11111111, 4'hF);
    rd_a("way1_keep", 1, 5, 2, 32'hDEADBEEF);
    // fill way0 addr3 with gaps, then change way/addr mid-fill
    way = 0; addr = 3; fill_start = 1'b1;
    @(negedge clk);
    fill_start = 1'b0; way = 1; addr = 7;
    check("fill_rdy", 32'(fill_ready), 1);
    check("fill_busy", 32'(busy), 1);
    pat = 7'b1100101; k = 0; done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      fill_valid = c < 7 ? pat[c] : 1'b0;
      fill_data = 32'h10 + 32'(k);
      @(negedge clk);
      done_cnt += int'(fill_done);
      if (fill_valid) k++;
      if (c == 6) begin
        check("fill_done", 32'(fill_done), 1);
        check("fill_idle", 32'(busy), 0);
      end
    end
    fill_valid = 1'b0;
    check("done_once", 32'(done_cnt), 1);
    // evict the same block with toggling ready and an ignored write
    way = 0; addr = 3; evict_start = 1'b1;
    @(negedge clk);
    evict_start = 1'b0; wr = 1'b1; off = 0; wdata = 32'hFFFFFFFF; be = 4'hF;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      evict_ready = c % 2 == 1;
      if (ev_valid) check($sformatf("ev%0d", n), ev_data, 32'h10 + 32'(n));
      if (ev_valid && evict_ready) n++;
      @(negedge clk);
      wr = 1'b0; way = 1; addr = 7;
    end
    evict_ready = 1'b0;
    check("ev_count", 32'(n), 4);
    check("ev_idle", 32'(busy), 0);
    check("ev_vld_off", 32'(ev_valid), 0);
    rd_a("ev_nowr", 0, 3, 0, 32'h10);
    rd_a("fill_w3", 0, 3, 3, 32'h13);
    // fill_start beats wr, rd ignored in FILL, reset aborts after two words
    for (int i = 0; i < 4; i++) wr_a(1, 2, 2'(i), 32'hA0 + 32'(i), 4'hF);
    way = 1; addr = 2; off = 3; wdata = 32'hBAD; be = 4'hF; fill_start = 1'b1; wr = 1'b1;
    @(negedge clk);
    fill_start = 1'b0; wr = 1'b0;
    check("v4_busy", 32'(busy), 1);
    rd = 1'b1; off = 0; fill_valid = 1'b1; fill_data = 32'hC0;
    @(negedge clk);
    check("v4_nord0", 32'(rd_valid), 0);
    fill_data = 32'hC1;
    @(negedge clk);
    check("v4_nord1", 32'(rd_valid), 0);
    rd = 1'b0; fill_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("v5_busy", 32'(busy), 0);
    check("v5_frdy", 32'(fill_ready), 0);
    check("v5_data", rdata, 0);
    check("v5_evd", ev_data, 0);
    check("v5_fdone", 32'(fill_done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_a("v5_w0", 1, 2, 0, 32'hC0);
    rd_a("v5_w1", 1, 2, 1, 32'hC1);
    rd_a("v5_w2", 1, 2, 2, 32'hA2);
    rd_a("v5_w3", 1, 2, 3, 32'hA3);
    // 4-way, 8-word instance: distinct word per way/offset at one address
    for (int w = 0; w < 4; w++)
      for (int o = 0; o < 8; o++) wr_b(2'(w), 3'(o), {16'hA5A5, 8'(w), 8'(o)});
    for (int w = 0; w < 4; w++)
      for (int o = 0; o < 8; o++) rd_b($sformatf("v6_%0d_%0d", w, o), 2'(w), 3'(o), {16'hA5A5, 8'(w), 8'(o)});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
